// File: rtl/dm_cache_pkg.sv
// Shared sizing, FSM state type and address-field helpers for the direct-mapped cache.
// Processor addresses are word addresses: {tag, index, word offset}.
package dm_cache_pkg;
   localparam int NUM_LINES = 8;
   localparam int WORD_W    = 32;
   localparam int LINE_W    = 128;
   localparam int ADDR_W    = 30;
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_W - 2 - IDX_W;
   localparam int BLK_W     = ADDR_W - 2;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[2 +: IDX_W];
   endfunction

   function automatic logic [1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[1:0];
   endfunction

   function automatic logic [BLK_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:2];
   endfunction
endpackage

// File: rtl/dm_cache_array.sv
// Tag/data/valid/dirty storage: one combinational read port, one write port
// that either merges a single word or fills a whole line.
module dm_cache_array
   import dm_cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              word_we,
   input  logic [1:0]        word_off,
   input  logic [WORD_W-1:0] word_data,
   input  logic              fill_we,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_line,
   input  logic              clean_we
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   // Only the status bits are reset; stale tag/data are masked by valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= 1'b0;
      end else if (word_we) begin
         dirty_q[wr_idx] <= 1'b1;
      end else if (clean_we) begin
         dirty_q[wr_idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[wr_idx] <= fill_line;
         tag_q[wr_idx]  <= fill_tag;
      end else if (word_we) begin
         data_q[wr_idx][word_off*WORD_W +: WORD_W] <= word_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate direct-mapped cache controller: hit/miss FSM plus
// registered request outputs toward the 128-bit slow memory.
module dm_cache_ctrl
   import dm_cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              proc_read,
   input  logic              proc_write,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [WORD_W-1:0] proc_wdata,
   output logic [WORD_W-1:0] proc_rdata,
   output logic              proc_stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [BLK_W-1:0]  mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   state_e            state_q, state_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [BLK_W-1:0]  mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              rd_valid, rd_dirty;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_line;
   logic              word_we, fill_we, clean_we;
   logic [IDX_W-1:0]  idx;
   logic              req, hit;

   assign idx = addr_idx(proc_addr);
   assign req = proc_read | proc_write;
   assign hit = rd_valid && (rd_tag == addr_tag(proc_addr));

   dm_cache_array u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_idx    (idx),
      .word_we   (word_we),
      .word_off  (addr_off(proc_addr)),
      .word_data (proc_wdata),
      .fill_we   (fill_we),
      .fill_tag  (addr_tag(proc_addr)),
      .fill_line (mem_rdata),
      .clean_we  (clean_we)
   );

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      word_we     = 1'b0;
      fill_we     = 1'b0;
      clean_we    = 1'b0;
      case (state_q)
         COMPARE: begin
            if (req) begin
               // A simultaneous read+write is handled as a write.
               if (hit) begin
                  word_we = proc_write;
               end else if (rd_valid && rd_dirty) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {rd_tag, idx};
                  mem_wdata_d = rd_line;
               end else begin
                  state_d    = ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = addr_blk(proc_addr);
               end
            end
         end
         WRITEBACK: begin
            if (mem_ready) begin
               state_d     = ALLOCATE;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = addr_blk(proc_addr);
               clean_we    = 1'b1;
            end
         end
         ALLOCATE: begin
            if (mem_ready) begin
               state_d    = COMPARE;
               mem_read_d = 1'b0;
               fill_we    = 1'b1;
            end
         end
         default: state_d = COMPARE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COMPARE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign proc_stall = (state_q != COMPARE) || (req && !hit);
   assign proc_rdata = rd_line[addr_off(proc_addr)*WORD_W +: WORD_W];
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: slow-memory model, directed vector table, reset and
// stray-ready sequences, then random traffic against a flat-memory reference.
module tb_dm_cache_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata, proc_rdata;
   logic         proc_stall;
   logic         mem_read, mem_write, mem_ready;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mdl_ready, stray_ready;

   assign mem_ready = mdl_ready | stray_ready;

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Backing store: untouched word i holds i.
   logic [127:0] bmem [int];
   logic [31:0]  ref_w [int];

   function automatic logic [127:0] blk_rd(input int b);
      if (bmem.exists(b)) return bmem[b];
      return {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)};
   endfunction

   function automatic logic [31:0] bword(input int a);
      logic [127:0] l;
      l = blk_rd(a >> 2);
      return l[32*(a%4) +: 32];
   endfunction

   // Architectural value of a word: last store, else backing memory.
   function automatic logic [31:0] ref_rd(input int a);
      if (ref_w.exists(a)) return ref_w[a];
      return bword(a);
   endfunction

   int           mem_lat = 1;
   int           n_rd = 0, n_wr = 0;
   logic [27:0]  last_rd_addr = '0, last_wb_addr = '0;
   logic [127:0] last_wb_data = '0;

   initial begin
      bit          is_wr, aborted;
      logic [27:0] a;
      int          lat;
      mdl_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         while (rst_n && (mem_read || mem_write)) begin
            is_wr   = mem_write;
            a       = mem_addr;
            lat     = mem_lat;
            aborted = 1'b0;
            for (int k = 0; k < lat; k++) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
            end
            if (!aborted && rst_n) begin
               if (is_wr) begin
                  n_wr++;
                  last_wb_addr = a;
                  last_wb_data = mem_wdata;
                  for (int k = 0; k < 4; k++)
                     check("wb_word", 128'(mem_wdata[32*k +: 32]), 128'(ref_rd(int'(a)*4 + k)));
                  bmem[int'(a)] = mem_wdata;
                  $display("mem write blk=%0h data=%032h", a, mem_wdata);
               end else begin
                  n_rd++;
                  last_rd_addr = a;
                  mem_rdata = blk_rd(int'(a));
                  $display("mem read  blk=%0h data=%032h", a, mem_rdata);
               end
               mdl_ready = 1'b1;
               @(negedge clk);
               mdl_ready = 1'b0;
               #1;
               check("req_drop", 128'(is_wr ? mem_write : mem_read), 128'(0));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (mem_read && mem_write) begin
            bad++;
            $display("FAIL rd_wr_both: got read=1 write=1 want at most one");
         end
      end
   end

   task automatic access(input logic [1:0] rw, input logic [29:0] a, input logic [31:0] d,
                         output logic [31:0] r, output int st);
      @(negedge clk);
      proc_read  = rw[1];
      proc_write = rw[0];
      proc_addr  = a;
      proc_wdata = d;
      st = 0;
      #1;
      while (proc_stall && st < 200) begin
         @(negedge clk);
         #1;
         st++;
      end
      if (proc_stall) begin
         total++;
         bad++;
         $display("FAIL timeout: addr %0h still stalled, want completion", a);
      end
      r = proc_rdata;
      @(posedge clk);
      #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      if (rw[0]) ref_w[int'(a)] = d;
      $display("access rw=%b addr=%0h wdata=%0h rdata=%0h stalls=%0d", rw, a, d, r, st);
   endtask

   typedef struct {
      logic [1:0]  rw;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          chk_rd;
      int          exp_st;
      int          exp_drd;
      int          exp_dwr;
      logic [27:0] exp_rdaddr;
   } vec_t;

   vec_t tbl [10];

   logic [31:0] r;
   int          st, n0r, n0w;
   bit          c_valid [8];
   bit          c_dirty [8];
   int          c_tag   [8];

   initial begin
      tbl[0] = '{2'b10, 30'h00, 32'h0,        32'h00000000, 1'b1, 3, 1, 0, 28'h0};
      tbl[1] = '{2'b10, 30'h03, 32'h0,        32'h00000003, 1'b1, 0, 0, 0, 28'h0};
      tbl[2] = '{2'b01, 30'h01, 32'hDEADBEEF, 32'h0,        1'b0, 0, 0, 0, 28'h0};
      tbl[3] = '{2'b10, 30'h01, 32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 0, 28'h0};
      tbl[4] = '{2'b10, 30'h20, 32'h0,        32'h00000020, 1'b1, 5, 1, 1, 28'h8};
      tbl[5] = '{2'b01, 30'h45, 32'h12345678, 32'h0,        1'b0, 3, 1, 0, 28'h11};
      tbl[6] = '{2'b10, 30'h45, 32'h0,        32'h12345678, 1'b1, 0, 0, 0, 28'h0};
      tbl[7] = '{2'b10, 30'h01, 32'h0,        32'hDEADBEEF, 1'b1, 3, 1, 0, 28'h0};
      tbl[8] = '{2'b11, 30'h45, 32'hCAFEF00D, 32'h0,        1'b0, 0, 0, 0, 28'h0};
      tbl[9] = '{2'b10, 30'h45, 32'h0,        32'hCAFEF00D, 1'b1, 0, 0, 0, 28'h0};

      proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
      stray_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst_mem_read",  128'(mem_read),   128'(0));
      check("rst_mem_write", 128'(mem_write),  128'(0));
      check("rst_mem_addr",  128'(mem_addr),   128'(0));
      check("rst_mem_wdata", mem_wdata,        128'(0));
      check("rst_stall",     128'(proc_stall), 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      mem_lat = 1;
      for (int i = 0; i < 10; i++) begin
         n0r = n_rd;
         n0w = n_wr;
         access(tbl[i].rw, tbl[i].addr, tbl[i].wdata, r, st);
         check($sformatf("vec%0d_stalls", i), 128'(st), 128'(tbl[i].exp_st));
         if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), 128'(r), 128'(tbl[i].exp_rd));
         check($sformatf("vec%0d_nread", i),  128'(n_rd - n0r), 128'(tbl[i].exp_drd));
         check($sformatf("vec%0d_nwrite", i), 128'(n_wr - n0w), 128'(tbl[i].exp_dwr));
         if (tbl[i].exp_drd > 0) check($sformatf("vec%0d_rdaddr", i), 128'(last_rd_addr), 128'(tbl[i].exp_rdaddr));
      end
      check("wb_addr", 128'(last_wb_addr), 128'(0));
      check("wb_data", last_wb_data, {32'h3, 32'h2, 32'hDEADBEEF, 32'h0});
      check("mem_word1", 128'(bword(1)), 128'(32'hDEADBEEF));

      // Stray mem_ready while idle in COMPARE.
      repeat (3) @(negedge clk);
      stray_ready = 1'b1;
      @(negedge clk);
      stray_ready = 1'b0;
      #1;
      check("stray_mem_read",  128'(mem_read),   128'(0));
      check("stray_mem_write", 128'(mem_write),  128'(0));
      check("stray_stall",     128'(proc_stall), 128'(0));
      n0r = n_rd; n0w = n_wr;
      access(2'b10, 30'h45, 32'h0, r, st);
      check("stray_hit_stalls", 128'(st), 128'(0));
      check("stray_hit_rdata",  128'(r), 128'(32'hCAFEF00D));
      check("stray_traffic",    128'((n_rd - n0r) + (n_wr - n0w)), 128'(0));

      // Reset while a refill is outstanding.
      mem_lat = 5;
      @(negedge clk);
      proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h60;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("alloc_mem_read", 128'(mem_read), 128'(1));
      rst_n = 1'b0;
      #1;
      check("midrst_mem_read",  128'(mem_read),  128'(0));
      check("midrst_mem_write", 128'(mem_write), 128'(0));
      proc_read = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ref_w.delete();
      repeat (8) @(negedge clk);
      mem_lat = 1;
      n0r = n_rd;
      access(2'b10, 30'h03, 32'h0, r, st);
      check("postrst_03_stalls", 128'(st), 128'(3));
      check("postrst_03_rdata",  128'(r), 128'(32'h3));
      check("postrst_03_nread",  128'(n_rd - n0r), 128'(1));
      access(2'b10, 30'h45, 32'h0, r, st);
      check("postrst_45_stalls", 128'(st), 128'(3));
      check("postrst_45_rdata",  128'(r), 128'(32'h45));

      // Random traffic against the flat-memory reference.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ref_w.delete();
      for (int i = 0; i < 8; i++) begin
         c_valid[i] = 1'b0; c_dirty[i] = 1'b0; c_tag[i] = 0;
      end
      for (int n = 0; n < 200; n++) begin
         int          tg, ix, of, ex_st;
         logic [29:0] a;
         logic [31:0] d, ex_r;
         logic [1:0]  rw;
         bit          hit;
         tg = int'($urandom_range(0, 3));
         ix = int'($urandom_range(0, 7));
         of = int'($urandom_range(0, 3));
         a  = 30'(tg*32 + ix*4 + of);
         d  = $urandom;
         rw = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         mem_lat = int'($urandom_range(0, 2));
         ex_r = ref_rd(int'(a));
         hit  = c_valid[ix] && (c_tag[ix] == tg);
         if (hit) ex_st = 0;
         else if (c_valid[ix] && c_dirty[ix]) ex_st = 3 + 2*mem_lat;
         else ex_st = 2 + mem_lat;
         if (!hit) begin
            c_valid[ix] = 1'b1; c_tag[ix] = tg; c_dirty[ix] = 1'b0;
         end
         if (rw[0]) c_dirty[ix] = 1'b1;
         access(rw, a, d, r, st);
         check($sformatf("rnd%0d_stalls", n), 128'(st), 128'(ex_st));
         if (rw[1]) check($sformatf("rnd%0d_rdata", n), 128'(r), 128'(ex_r));
      end

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
